// File: rtl/dbg_cmd_tx_if.sv
// Command stream interface between the debug command initiator and the
// debug governor's 32-bit cmd_in AXI stream port.
//
// Signals:
//   TDATA   32  command stream data (header or payload word)
//   TVALID   1  command stream valid, driven by the initiator
//   TREADY   1  command stream ready, driven by the governor
//
// Modports:
//   master  initiator side (drives TDATA/TVALID, samples TREADY)
//   slave   governor side  (samples TDATA/TVALID, drives TREADY)
interface dbg_cmd_tx_if;
    logic [31:0] TDATA;
    logic        TVALID;
    logic        TREADY;

    modport master (output TDATA, output TVALID, input TREADY);
    modport slave  (input TDATA, input TVALID, output TREADY);
endinterface

// File: rtl/dbg_cmd_tx.sv
// dbg_cmd_tx: command initiator for the debug governor's command stream.
// A host request (opcode, argument, payload) is latched on acceptance and
// serialised as one header beat {op, arg}; the inject opcode is followed by
// NBEATS payload words, least significant word first. Completed commands are
// counted in a wrapping 16-bit counter.
//
// Optional feature: define DBG_CMD_TX_TIMEOUT_EN to abort a command whose
// stream stalls for TIMEOUT_CYCLES consecutive cycles and raise the sticky
// timeout_err flag. Without it the stream waits indefinitely, timeout_err is
// tied low and err_clr is ignored.
//
// Ports:
//   clk          clock
//   rst          asynchronous active-low reset
//   host_op      command opcode
//   host_arg     command argument
//   host_data    inject payload (ignored for other opcodes)
//   host_valid   request valid
//   host_ready   request accepted when high together with host_valid
//   cmd_out      command stream (dbg_cmd_tx_if master modport)
//   busy         high whenever a command is in flight
//   sent_count   number of fully transmitted commands (wraps)
//   timeout_err  sticky stall-timeout flag
//   err_clr      clears timeout_err
module dbg_cmd_tx #(
    parameter int         DATA_WIDTH     = 64,
    parameter logic [3:0] INJ_OP         = 4'h2,
    parameter int         TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            host_op,
    input  logic [27:0]           host_arg,
    input  logic [DATA_WIDTH-1:0] host_data,
    input  logic                  host_valid,
    output logic                  host_ready,
    dbg_cmd_tx_if.master          cmd_out,
    output logic                  busy,
    output logic [15:0]           sent_count,
    output logic                  timeout_err,
    input  logic                  err_clr
);
    localparam int NBEATS = DATA_WIDTH / 32;
    localparam int BEAT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;

    if ((DATA_WIDTH % 32) != 0 || DATA_WIDTH < 32 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("dbg_cmd_tx: DATA_WIDTH must be a positive multiple of 32 and TIMEOUT_CYCLES >= 1");
    end

    typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

    state_t                  state, state_nxt;
    logic [3:0]              op;
    logic [27:0]             arg;
    logic [DATA_WIDTH-1:0]   data;
    logic [BEAT_W-1:0]       beat;
    logic                    tvalid;
    logic [31:0]             tdata;
    logic                    handshake;
    logic                    last_beat;
    logic                    done;
    logic                    can_accept;
    logic                    accept;
    logic                    abort;

    assign cmd_out.TVALID = tvalid;
    assign cmd_out.TDATA  = tdata;
    assign busy           = (state != IDLE);
    // Gate with rst only on the output so the internal accept path stays
    // purely synchronous.
    assign host_ready     = rst & can_accept;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        tvalid    = 1'b0;
        tdata     = '0;
        handshake = 1'b0;
        last_beat = 1'b0;
        unique case (state)
            IDLE: ;
            HDR: begin
                tvalid    = 1'b1;
                tdata     = {op, arg};
                handshake = cmd_out.TREADY;
                last_beat = (op != INJ_OP);
                if (handshake && op == INJ_OP) state_nxt = DATA;
            end
            DATA: begin
                tvalid    = 1'b1;
                // data is shifted down after every payload handshake, so the
                // current word always sits in the low 32 bits.
                tdata     = data[31:0];
                handshake = cmd_out.TREADY;
                last_beat = (beat == BEAT_W'(NBEATS - 1));
            end
            default: state_nxt = IDLE;
        endcase
        done       = handshake & last_beat;
        // Ready also in the final-beat handshake cycle so that back-to-back
        // requests go straight to the next header without an idle bubble.
        can_accept = (state == IDLE) | done;
        accept     = host_valid & can_accept;
        if (can_accept) state_nxt = accept ? HDR : IDLE;
        if (abort)      state_nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            op   <= host_op;
            arg  <= host_arg;
            data <= host_data;
        end else if (state == DATA && handshake) begin
            data <= data >> 32;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            beat       <= '0;
            sent_count <= 16'h0000;
        end else begin
            if (state == HDR && handshake)       beat <= '0;
            else if (state == DATA && handshake) beat <= beat + BEAT_W'(1);
            if (done) sent_count <= sent_count + 16'h0001;
        end
    end

`ifdef DBG_CMD_TX_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] stall_cnt;
    logic             stalled;

    assign stalled = tvalid & ~cmd_out.TREADY;
    // The stall that would bring the counter to TIMEOUT_CYCLES aborts the
    // command at this edge; TVALID is low from the next cycle.
    assign abort   = stalled && (stall_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt   <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (!stalled || abort) stall_cnt <= '0;
            else                   stall_cnt <= stall_cnt + CNT_W'(1);
            // A new timeout takes priority over a simultaneous clear.
            if (abort)        timeout_err <= 1'b1;
            else if (err_clr) timeout_err <= 1'b0;
        end
    end
`else
    logic unused_err_clr;

    assign abort          = 1'b0;
    assign timeout_err    = 1'b0;
    assign unused_err_clr = err_clr;
`endif

endmodule

// File: tb/tb_dbg_cmd_tx.sv
// Self-checking bench for dbg_cmd_tx. A queue-based reference model holds
// the words every accepted request must produce on the stream; a negedge
// monitor compares the DUT against it every cycle, and directed sections
// check the literal beat values, cycle spacing and counter wrap.
module tb_dbg_cmd_tx;
    localparam int         DATA_WIDTH = 64;
    localparam int         NBEATS     = DATA_WIDTH / 32;
    localparam logic [3:0] INJ_OP     = 4'h2;
    localparam int         TMO        = 16;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [3:0]            host_op;
    logic [27:0]           host_arg;
    logic [DATA_WIDTH-1:0] host_data;
    logic                  host_valid;
    logic                  host_ready;
    logic                  busy;
    logic [15:0]           sent_count;
    logic                  timeout_err;
    logic                  err_clr;

    dbg_cmd_tx_if cmd_if ();

    dbg_cmd_tx #(
        .DATA_WIDTH    (DATA_WIDTH),
        .INJ_OP        (INJ_OP),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .host_op    (host_op),
        .host_arg   (host_arg),
        .host_data  (host_data),
        .host_valid (host_valid),
        .host_ready (host_ready),
        .cmd_out    (cmd_if),
        .busy       (busy),
        .sent_count (sent_count),
        .timeout_err(timeout_err),
        .err_clr    (err_clr)
    );

    initial forever #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] w;
        bit          last;
    } beat_t;

    beat_t       mq[$];
    logic [31:0] seen[$];
    int          seen_cyc[$];
    logic [15:0] exp_cnt = 16'h0;
    int          acc_cnt = 0;
    int          ncyc    = 0;
    bit          mon_en  = 1'b1;
    bit          rand_rdy = 1'b0;

    always @(negedge clk) begin
        beat_t                 b;
        logic [DATA_WIDTH-1:0] d;
        bit                    exp_v;
        bit                    exp_rdy;
        ncyc++;
        if (!rst) begin
            mq.delete();
            exp_cnt = 16'h0;
            chk("rst_tvalid", cmd_if.TVALID, 1'b0);
            chk("rst_host_ready", host_ready, 1'b0);
            chk("rst_sent_count", sent_count, 16'h0);
        end else if (mon_en) begin
            exp_v = (mq.size() != 0);
            chk("tvalid", cmd_if.TVALID, exp_v);
            chk("busy", busy, exp_v);
            if (exp_v) chk("tdata", cmd_if.TDATA, mq[0].w);
            exp_rdy = !exp_v || (mq.size() == 1 && mq[0].last && cmd_if.TREADY);
            chk("host_ready", host_ready, exp_rdy);
            chk("sent_count", sent_count, exp_cnt);
`ifndef DBG_CMD_TX_TIMEOUT_EN
            chk("timeout_err_tied", timeout_err, 1'b0);
`endif
            if (exp_v && cmd_if.TVALID && cmd_if.TREADY) begin
                seen.push_back(cmd_if.TDATA);
                seen_cyc.push_back(ncyc);
                if (mq[0].last) exp_cnt = exp_cnt + 16'h1;
                void'(mq.pop_front());
            end
            if (host_valid && host_ready) begin
                acc_cnt++;
                b.w    = {host_op, host_arg};
                b.last = (host_op != INJ_OP);
                mq.push_back(b);
                if (host_op == INJ_OP) begin
                    d = host_data;
                    for (int i = 0; i < NBEATS; i++) begin
                        b.w    = d[32*i +: 32];
                        b.last = (i == NBEATS - 1);
                        mq.push_back(b);
                    end
                end
            end
        end
    end

    function automatic logic [31:0] seen_at(input int i);
        if (i >= 0 && i < seen.size()) return seen[i];
        return 'x;
    endfunction

    function automatic int cyc_at(input int i);
        if (i >= 0 && i < seen_cyc.size()) return seen_cyc[i];
        return -1000;
    endfunction

    // ---------------- drivers ----------------
    task automatic host_req(input logic [3:0] op, input logic [27:0] arg,
                            input logic [DATA_WIDTH-1:0] d);
        bit got = 1'b0;
        host_op    = op;
        host_arg   = arg;
        host_data  = d;
        host_valid = 1'b1;
        for (int n = 0; n < 2000 && !got; n++) begin
            if (rand_rdy) cmd_if.TREADY = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            got = host_ready;
            @(posedge clk);
            #1;
        end
        host_valid = 1'b0;
        host_op    = 4'($urandom);
        host_arg   = 28'($urandom);
        host_data  = DATA_WIDTH'({$urandom, $urandom});
        if (!got) chk("req_accept_timeout", 1'b0, 1'b1);
    endtask

    task automatic drain();
        int n = 0;
        while ((mq.size() != 0 || busy) && n < 2000) begin
            if (rand_rdy) cmd_if.TREADY = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 2000) chk("drain_timeout", 1'b0, 1'b1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int base;
        int target;
        int n;
        logic [3:0] rop;

        rst           = 1'b0;
        host_valid    = 1'b0;
        host_op       = 4'h0;
        host_arg      = 28'h0;
        host_data     = '0;
        err_clr       = 1'b0;
        cmd_if.TREADY = 1'b0;

        #1;
        chk("por_tvalid", cmd_if.TVALID, 1'b0);
        chk("por_tdata", cmd_if.TDATA, 32'h0);
        chk("por_busy", busy, 1'b0);
        chk("por_count", sent_count, 16'h0);
        chk("por_host_ready", host_ready, 1'b0);
        chk("por_timeout_err", timeout_err, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("idle_host_ready", host_ready, 1'b1);

        // single-beat command
        cmd_if.TREADY = 1'b1;
        base = seen.size();
        host_req(4'h1, 28'h0000ABC, '0);
        drain();
        chk("t1_beat", seen_at(base), 32'h10000ABC);
        chk("t1_count", sent_count, 16'd1);
        chk("t1_busy", busy, 1'b0);

        // inject, full throughput
        base = seen.size();
        host_req(INJ_OP, 28'h0, 64'hDEADBEEF_01234567);
        drain();
        chk("t2_hdr", seen_at(base), 32'h20000000);
        chk("t2_w0", seen_at(base + 1), 32'h01234567);
        chk("t2_w1", seen_at(base + 2), 32'hDEADBEEF);
        chk("t2_gap0", cyc_at(base + 1) - cyc_at(base), 1);
        chk("t2_gap1", cyc_at(base + 2) - cyc_at(base + 1), 1);
        chk("t2_count", sent_count, 16'd2);

        // inject with a 5-cycle stall on the first payload word
        base = seen.size();
        cmd_if.TREADY = 1'b0;
        host_req(INJ_OP, 28'h0000055, 64'h0BADF00D_CAFEBABE);
        cmd_if.TREADY = 1'b1;
        @(posedge clk);
        #1;
        cmd_if.TREADY = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t3_hold_valid", cmd_if.TVALID, 1'b1);
            chk("t3_hold_data", cmd_if.TDATA, 32'hCAFEBABE);
        end
        @(posedge clk);
        #1;
        cmd_if.TREADY = 1'b1;
        drain();
        chk("t3_hdr", seen_at(base), 32'h20000055);
        chk("t3_w0", seen_at(base + 1), 32'hCAFEBABE);
        chk("t3_w1", seen_at(base + 2), 32'h0BADF00D);
        chk("t3_stall_gap", cyc_at(base + 1) - cyc_at(base), 6);
        chk("t3_next_gap", cyc_at(base + 2) - cyc_at(base + 1), 1);
        chk("t3_count", sent_count, 16'd3);

        // back-to-back single-beat commands
        base = seen.size();
        host_req(4'h1, 28'h1234567, '0);
        host_req(4'h3, 28'h7654321, '0);
        drain();
        chk("t4_hdr0", seen_at(base), 32'h11234567);
        chk("t4_hdr1", seen_at(base + 1), 32'h37654321);
        chk("t4_no_gap", cyc_at(base + 1) - cyc_at(base), 1);
        chk("t4_count", sent_count, 16'd5);

        // randomized traffic with random backpressure
        rand_rdy = 1'b1;
        for (int k = 0; k < 300; k++) begin
            rop = ($urandom_range(0, 2) == 0) ? INJ_OP : 4'($urandom);
            host_req(rop, 28'($urandom), DATA_WIDTH'({$urandom, $urandom}));
            repeat ($urandom_range(0, 2)) begin
                cmd_if.TREADY = ($urandom_range(0, 3) != 0);
                @(posedge clk);
                #1;
            end
        end
        drain();
        rand_rdy      = 1'b0;
        cmd_if.TREADY = 1'b1;
        chk("rand_count", sent_count, exp_cnt);
        chk("rand_idle", busy, 1'b0);

        // counter wrap
        target     = acc_cnt + int'(16'hFFFF - exp_cnt);
        host_op    = 4'h1;
        host_arg   = 28'h00000AA;
        host_valid = 1'b1;
        n = 0;
        while (acc_cnt < target && n < 70000) begin
            @(posedge clk);
            #1;
            n++;
        end
        host_valid = 1'b0;
        if (n >= 70000) chk("wrap_fill_timeout", 1'b0, 1'b1);
        drain();
        chk("wrap_pre", sent_count, 16'hFFFF);
        host_req(4'h1, 28'h00000BB, '0);
        drain();
        chk("wrap_post", sent_count, 16'h0000);

`ifdef DBG_CMD_TX_TIMEOUT_EN
        // stall timeout: model paused, checks are direct
        mon_en        = 1'b0;
        cmd_if.TREADY = 1'b0;
        host_req(4'h5, 28'h0000321, '0);
        repeat (TMO - 1) @(posedge clk);
        @(negedge clk);
        chk("to_err_early", timeout_err, 1'b0);
        chk("to_valid_held", cmd_if.TVALID, 1'b1);
        @(negedge clk);
        chk("to_err_set", timeout_err, 1'b1);
        chk("to_valid_drop", cmd_if.TVALID, 1'b0);
        chk("to_busy", busy, 1'b0);
        chk("to_count", sent_count, exp_cnt);
        @(negedge clk);
        chk("to_err_sticky", timeout_err, 1'b1);
        @(posedge clk);
        #1;
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        @(negedge clk);
        chk("to_err_clr", timeout_err, 1'b0);
        cmd_if.TREADY = 1'b1;
        mon_en        = 1'b1;
`endif

        // reset in the middle of an inject
        cmd_if.TREADY = 1'b1;
        host_req(INJ_OP, 28'h0000001, 64'h11112222_33334444);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_tvalid", cmd_if.TVALID, 1'b0);
        chk("mid_rst_tdata", cmd_if.TDATA, 32'h0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_host_ready", host_ready, 1'b0);
        chk("mid_rst_count", sent_count, 16'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        base = seen.size();
        host_req(4'h7, 28'h0000077, '0);
        drain();
        chk("post_rst_beat", seen_at(base), 32'h70000077);
        chk("post_rst_count", sent_count, 16'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
